jtframe_dwnld_sched: RTL

- Sequences ROM download bytes from the data_io ioctl interface into the 16-bit SDRAM write port.
- Packs bytes into masked words and buffers them in a small FIFO. Throttles the io controller through ioctl_wait.
- Shares the SDRAM port with the game read requester: the download owns the port from download start until the FIFO drains; the game owns it otherwise.
- Sits between data_io and the SDRAM controller in the top level.

---
 rtl/jtframe_dwnld_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/jtframe_dwnld_sched.sv
// ROM download scheduler: packs data_io bytes into masked 16-bit words, queues them
// and arbitrates the single SDRAM port between download writes and game reads.
module jtframe_dwnld_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 24
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          dwnld_busy,
  output logic          ovf_err,
  input  logic          game_req,
  input  logic [AW-1:0] game_addr,
  output logic          game_ack,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_mask,
  input  logic          sdram_ack
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } word_t;

  typedef enum logic [1:0] {IDLE, DL_RUN, DL_FLUSH, DL_DRAIN} state_t;

  state_t        state_q, state_d;
  word_t         pack_q, pack_d;
  word_t         fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, dl_q, dl_pend_q, dl_pend_d;
  logic          wait_q, ovf_q, ovf_d, wreq_q, wreq_d;

  logic          accept, dl_rise, owner, pop, full, push, push_ok, ovf_set;
  logic [AW-1:0] byte_waddr;
  word_t         head;

  assign accept     = ioctl_wr & ~wr_q & ioctl_download;
  assign dl_rise    = ioctl_download & ~dl_q;
  assign byte_waddr = ioctl_addr[AW:1];
  assign owner      = state_q != IDLE;
  assign pop        = wreq_q & sdram_ack;
  assign full       = cnt_q == CW'(FIFO_DEPTH);
  assign head       = fifo_q[rptr_q];

  // A full word, a flush, or a byte for another word evicts the pack register;
  // the incoming byte then lands in the emptied register in the same cycle.
  always_comb begin
    pack_d = pack_q;
    push   = 1'b0;
    if (pack_q.mask == 2'b11 ||
        (state_q == DL_FLUSH && pack_q.mask != 2'b00) ||
        (accept && pack_q.mask != 2'b00 && byte_waddr != pack_q.addr)) begin
      push   = 1'b1;
      pack_d = '0;
    end
    if (accept) begin
      if (pack_d.mask == 2'b00) pack_d.addr = byte_waddr;
      if (ioctl_addr[0]) pack_d.data[15:8] = ioctl_dout;
      else               pack_d.data[7:0]  = ioctl_dout;
      pack_d.mask[ioctl_addr[0]] = 1'b1;
    end
  end

  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    dl_pend_d = dl_pend_q;
    wreq_d    = wreq_q;
    ovf_d     = ovf_q;
    if (dl_rise) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    case (state_q)
      // an outstanding game read must complete before the download takes the port
      IDLE: if (dl_rise || dl_pend_q) begin
        if (!game_req || sdram_ack) begin
          state_d   = DL_RUN;
          dl_pend_d = 1'b0;
        end else begin
          dl_pend_d = 1'b1;
        end
      end
      DL_RUN:   if (!ioctl_download) state_d = DL_FLUSH;
      DL_FLUSH: if (dl_rise) state_d = DL_RUN;
                else if (pack_q.mask == 2'b00) state_d = DL_DRAIN;
      DL_DRAIN: if (dl_rise) state_d = DL_RUN;
                else if (cnt_q == '0 && !wreq_q && pack_q.mask == 2'b00) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (pop)                                    wreq_d = 1'b0;
    else if (owner && cnt_q != '0 && !wreq_q)   wreq_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pack_q    <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      dl_q      <= 1'b0;
      dl_pend_q <= 1'b0;
      wait_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wreq_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pack_q    <= pack_d;
      cnt_q     <= cnt_d;
      wr_q      <= ioctl_wr;
      dl_q      <= ioctl_download;
      dl_pend_q <= dl_pend_d;
      wait_q    <= cnt_d >= CW'(FIFO_DEPTH - 1);
      ovf_q     <= ovf_d;
      wreq_q    <= wreq_d;
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) fifo_q[wptr_q] <= pack_q;
  end

  assign ioctl_wait = wait_q;
  assign dwnld_busy = owner;
  assign ovf_err    = ovf_q;
  assign game_ack   = ~owner & sdram_ack;
  assign sdram_req  = owner ? wreq_q    : game_req;
  assign sdram_we   = owner;
  assign sdram_addr = owner ? head.addr : game_addr;
  assign sdram_din  = owner ? head.data : 16'h0000;
  assign sdram_mask = owner ? head.mask : {2{game_req}};

endmodule
